// File: rtl/compare_scan_ctrl_if.sv
// rtl/compare_scan_ctrl_if.sv - byte stream valid/ready handshake into compare_scan_ctrl
interface compare_scan_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/compare_scan_ctrl.sv
// rtl/compare_scan_ctrl.sv - operand sequencer and flag collector around an 8-bit magnitude comparator
// Optional early exit on first match: COMPARE_SCAN_STOP_ON_MATCH_EN
module compare_scan_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  key,
    input  logic [COUNT_WIDTH-1:0] length,
    compare_scan_ctrl_if.slave     stream,
    output logic [DATA_WIDTH-1:0]  cmp_input_1,
    output logic [DATA_WIDTH-1:0]  cmp_input_2,
    input  logic                   cmp_gt,
    input  logic                   cmp_eq,
    input  logic                   cmp_lt,
    input  logic [DATA_WIDTH-1:0]  cmp_result,
    output logic [COUNT_WIDTH-1:0] gt_count,
    output logic [COUNT_WIDTH-1:0] eq_count,
    output logic [COUNT_WIDTH-1:0] lt_count,
    output logic [COUNT_WIDTH-1:0] match_index,
    output logic                   match_found,
    output logic                   flag_error,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] acc_cnt;
    logic [COUNT_WIDTH-1:0] sample_idx;
    logic                   pending;

    logic flags_onehot;
    logic sample_err;
    logic sample_eq;
    logic stop_hit;
    logic transfer;
    logic last_xfer;
    logic start_scan;

    // A sample is valid only with exactly one flag and, for equality, the result bus agreeing with the key
    assign flags_onehot = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                          ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                          ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);
    assign sample_err   = pending && (!flags_onehot || (cmp_eq && (cmp_result != cmp_input_2)));
    assign sample_eq    = pending && flags_onehot && cmp_eq && (cmp_result == cmp_input_2);

`ifdef COMPARE_SCAN_STOP_ON_MATCH_EN
    assign stop_hit = sample_eq && (state_q == ST_SCAN);
`else
    assign stop_hit = 1'b0;
`endif

    assign stream.data_ready = (state_q == ST_SCAN) && (acc_cnt < len_q) && !stop_hit;
    assign transfer          = stream.data_valid && stream.data_ready;
    assign last_xfer         = transfer && (acc_cnt == len_q - COUNT_WIDTH'(1));
    assign start_scan        = (state_q == ST_IDLE) && start;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The final sample overlaps DRAIN, so done lands two cycles after the last transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_xfer || stop_hit || (acc_cnt == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            acc_cnt     <= '0;
            sample_idx  <= '0;
            pending     <= 1'b0;
            cmp_input_1 <= '0;
            cmp_input_2 <= '0;
            gt_count    <= '0;
            eq_count    <= '0;
            lt_count    <= '0;
            match_index <= '0;
            match_found <= 1'b0;
            flag_error  <= 1'b0;
        end else if (start_scan) begin
            len_q       <= length;
            cmp_input_2 <= key;
            acc_cnt     <= '0;
            pending     <= 1'b0;
            gt_count    <= '0;
            eq_count    <= '0;
            lt_count    <= '0;
            match_index <= '0;
            match_found <= 1'b0;
            flag_error  <= 1'b0;
        end else begin
            pending <= transfer;
            if (transfer) begin
                cmp_input_1 <= stream.data_in;
                sample_idx  <= acc_cnt;
                acc_cnt     <= acc_cnt + COUNT_WIDTH'(1);
            end
            if (pending) begin
                if (sample_err) begin
                    flag_error <= 1'b1;
                end else if (cmp_gt) begin
                    if (gt_count != '1) gt_count <= gt_count + COUNT_WIDTH'(1);
                end else if (cmp_eq) begin
                    if (eq_count != '1) eq_count <= eq_count + COUNT_WIDTH'(1);
                end else begin
                    if (lt_count != '1) lt_count <= lt_count + COUNT_WIDTH'(1);
                end
                if (sample_eq && !match_found) begin
                    match_found <= 1'b1;
                    match_index <= sample_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_scan_ctrl.sv
// tb/tb_compare_scan_ctrl.sv - directed self-checking bench for compare_scan_ctrl
module tb_compare_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] key;
    logic [7:0] length;
    logic [7:0] cmp_input_1, cmp_input_2;
    logic       cmp_gt, cmp_eq, cmp_lt;
    logic [7:0] cmp_result;
    logic [7:0] gt_count, eq_count, lt_count, match_index;
    logic       match_found, flag_error, busy, done;
    logic       force_gt;

    logic [7:0] bytes [0:255];
    int         checks = 0;
    int         errors = 0;

    int         acc, lat;
    bit         saw_ready, got_done;

    compare_scan_ctrl_if #(.DATA_WIDTH(8)) stream_if ();

    compare_scan_ctrl #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key         (key),
        .length      (length),
        .stream      (stream_if),
        .cmp_input_1 (cmp_input_1),
        .cmp_input_2 (cmp_input_2),
        .cmp_gt      (cmp_gt),
        .cmp_eq      (cmp_eq),
        .cmp_lt      (cmp_lt),
        .cmp_result  (cmp_result),
        .gt_count    (gt_count),
        .eq_count    (eq_count),
        .lt_count    (lt_count),
        .match_index (match_index),
        .match_found (match_found),
        .flag_error  (flag_error),
        .busy        (busy),
        .done        (done)
    );

    // Comparator model; force_gt corrupts equal samples into a non-one-hot flag set
    assign cmp_gt     = (cmp_input_1 > cmp_input_2) || (force_gt && (cmp_input_1 == cmp_input_2));
    assign cmp_eq     = (cmp_input_1 == cmp_input_2);
    assign cmp_lt     = (cmp_input_1 < cmp_input_2);
    assign cmp_result = cmp_input_1;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input logic [7:0] k, input logic [7:0] n, input bit gap,
                            output int accepted, output int latency,
                            output bit ready_seen, output bit done_seen);
        int cyc, last, dcyc;
        bit drive;
        @(posedge clk); #1;
        key = k; length = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        accepted = 0; last = -100; dcyc = -1; ready_seen = 1'b0; cyc = 0;
        while (dcyc < 0 && cyc < 1000) begin
            drive = !(gap && (cyc % 2 == 1));
            stream_if.data_valid = drive;
            stream_if.data_in    = bytes[accepted % 256];
            #1;
            if (done) dcyc = cyc;
            if (stream_if.data_ready) ready_seen = 1'b1;
            if (drive && stream_if.data_ready) begin
                accepted++;
                last = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        stream_if.data_valid = 1'b0;
        done_seen = (dcyc >= 0);
        latency   = dcyc - last;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key = '0; length = '0; force_gt = 1'b0;
        stream_if.data_valid = 1'b0; stream_if.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", stream_if.data_ready, 0);
        check("rst_counts", {gt_count, eq_count, lt_count}, 0);
        check("rst_operands", {cmp_input_1, cmp_input_2}, 0);
        check("rst_match", {match_index, 6'd0, match_found, flag_error}, 0);
        rst_n = 1'b1;

        // Mixed bytes, back to back, with valid held high past the end
        bytes[0] = 8'h10; bytes[1] = 8'h40; bytes[2] = 8'h80; bytes[3] = 8'h40;
        for (int i = 4; i < 256; i++) bytes[i] = 8'h55;
        run_scan(8'h40, 8'd4, 1'b0, acc, lat, saw_ready, got_done);
        check("t1_done_seen", got_done, 1);
        check("t1_accepted", acc, 4);
        check("t1_latency", lat, 2);
        check("t1_lt", lt_count, 1);
        check("t1_eq", eq_count, 2);
        check("t1_gt", gt_count, 1);
        check("t1_match_index", match_index, 1);
        check("t1_match_found", match_found, 1);
        check("t1_flag_error", flag_error, 0);
        check("t1_key_operand", cmp_input_2, 8'h40);
        check("t1_done_one_cycle", done, 0);
        check("t1_idle_after", busy, 0);

        // Zero length goes straight to DONE
        run_scan(8'h40, 8'd0, 1'b0, acc, lat, saw_ready, got_done);
        check("len0_done_seen", got_done, 1);
        check("len0_ready_never", saw_ready, 0);
        check("len0_accepted", acc, 0);
        check("len0_counts", {gt_count, eq_count, lt_count}, 0);
        check("len0_match_found", match_found, 0);

        // Valid toggling 1,0,1,0
        bytes[0] = 8'h00; bytes[1] = 8'hFF;
        run_scan(8'hFF, 8'd2, 1'b1, acc, lat, saw_ready, got_done);
        check("gap_done_seen", got_done, 1);
        check("gap_accepted", acc, 2);
        check("gap_lt", lt_count, 1);
        check("gap_eq", eq_count, 1);
        check("gap_gt", gt_count, 0);
        check("gap_match_index", match_index, 1);

        // Longest scan, every byte below the key
        for (int i = 0; i < 256; i++) bytes[i] = 8'h00;
        run_scan(8'h01, 8'd255, 1'b0, acc, lat, saw_ready, got_done);
        check("long_done_seen", got_done, 1);
        check("long_accepted", acc, 255);
        check("long_lt", lt_count, 8'hFF);
        check("long_eq_gt", {eq_count, gt_count}, 0);
        check("long_match_found", match_found, 0);

        // Corrupted flags on the equal byte: error set, that byte not counted
        bytes[0] = 8'h40; bytes[1] = 8'h10;
        force_gt = 1'b1;
        run_scan(8'h40, 8'd2, 1'b0, acc, lat, saw_ready, got_done);
        force_gt = 1'b0;
        check("err_done_seen", got_done, 1);
        check("err_flag_sticky", flag_error, 1);
        check("err_counts", {gt_count, eq_count, lt_count}, 24'h00_00_01);
        check("err_match_found", match_found, 0);

        bytes[0] = 8'h05;
        run_scan(8'h05, 8'd1, 1'b0, acc, lat, saw_ready, got_done);
        check("err_cleared", flag_error, 0);
        check("err_next_eq", eq_count, 1);
        check("err_next_index", match_index, 0);
        check("err_next_found", match_found, 1);

        // Match in the middle: early exit only with the stop-on-match build
        bytes[0] = 8'h01; bytes[1] = 8'h22; bytes[2] = 8'h33;
        run_scan(8'h22, 8'd3, 1'b0, acc, lat, saw_ready, got_done);
        check("stop_done_seen", got_done, 1);
        check("stop_eq", eq_count, 1);
        check("stop_lt", lt_count, 1);
        check("stop_match_index", match_index, 1);
`ifdef COMPARE_SCAN_STOP_ON_MATCH_EN
        check("stop_gt", gt_count, 0);
        check("stop_accepted", acc, 2);
`else
        check("stop_gt", gt_count, 1);
        check("stop_accepted", acc, 3);
`endif

        // Asynchronous reset after 3 of 6 bytes
        @(posedge clk); #1;
        key = 8'h50; length = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stream_if.data_valid = 1'b1; stream_if.data_in = 8'h60;
        repeat (3) @(posedge clk);
        #1;
        stream_if.data_valid = 1'b0;
        check("mid_gt_before_reset", gt_count, 2);
        check("mid_busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_counts", {gt_count, eq_count, lt_count}, 0);
        check("mid_rst_operands", {cmp_input_1, cmp_input_2}, 0);
        check("mid_rst_ready", stream_if.data_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compare_scan_ctrl.md
Name: compare_scan_ctrl

Overview:
- Operand sequencer and flag collector placed around the 8-bit magnitude comparator.
- Accepts a key and a stream of data bytes over a valid/ready handshake.
- Drives each byte and the key into the comparator as registered operands, then samples the comparator's greater/equal/less flags and equal-result.
- Tallies the outcomes and reports the first match to the processor controller.

Parameters:
- DATA_WIDTH, 8, operand width; must match the comparator (8).
- COUNT_WIDTH, 8, width of the length field, counters and index.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin scan; sampled only in IDLE
- key  in  DATA_WIDTH  value compared against every byte; latched on start
- length  in  COUNT_WIDTH  number of bytes to scan; latched on start
- data_in  in  DATA_WIDTH  stream byte
- data_valid  in  1  data_in valid
- data_ready  out  1  block accepts data_in this cycle
- cmp_input_1  out  DATA_WIDTH  registered operand to comparator input_1 (data byte)
- cmp_input_2  out  DATA_WIDTH  registered operand to comparator input_2 (latched key)
- cmp_gt  in  1  comparator output_1 (input_1 > input_2)
- cmp_eq  in  1  comparator output_2 (equal)
- cmp_lt  in  1  comparator output_3 (less)
- cmp_result  in  DATA_WIDTH  comparator result bus
- gt_count  out  COUNT_WIDTH  number of bytes > key
- eq_count  out  COUNT_WIDTH  number of bytes == key
- lt_count  out  COUNT_WIDTH  number of bytes < key
- match_index  out  COUNT_WIDTH  0-based index of the first equal byte
- match_found  out  1  at least one equal byte seen
- flag_error  out  1  sticky; comparator flags were not one-hot, or eq result differed from the key
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the scan completes

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including operands, counters, match_index, match_found, flag_error, data_ready, busy, done.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On start=1, latch key and length and clear all counters, match_found, match_index and flag_error.
  - cmp_input_2 takes key the cycle after start.
  - Go to DONE if length==0, otherwise go to SCAN.
- SCAN:
  - data_ready=1 while the accepted count < latched length.
  - Handshake: a transfer occurs when data_valid && data_ready. On transfer, register data_in into cmp_input_1, set an internal pending bit, and increment the accept index.
  - Throughput is one byte per cycle.
  - Go to DRAIN in the cycle after the final transfer's operand is registered, i.e. when accept count == length.
- Flag sampling:
  - Occurs in every cycle where pending=1, one cycle after the transfer; the comparator is combinational on the registered operands.
  - Exactly one counter increments, per the asserted flag.
  - On the first cmp_eq: match_found←1 and match_index←index of that byte.
  - If the flags are not one-hot, or cmp_eq=1 and cmp_result≠latched key: flag_error←1 and no counter increments.
  - pending clears when no new transfer occurs that cycle.
- Counters saturate at all-ones and never wrap.
- DRAIN: data_ready=0; perform the final sample, then go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE. Counters, match and error outputs hold until the next start.
- start while busy is ignored.
- data_valid with data_ready=0 produces no transfer; data_in may change freely.
- Reset mid-scan aborts immediately to reset values; a partially received stream is discarded.
- Latency from last transfer to done: 2 cycles, since the sample and DRAIN share a cycle before DONE.

Optional Feature:
- Macro: COMPARE_SCAN_STOP_ON_MATCH_EN.
- Defined:
  - On the first equal sample, data_ready drops the same cycle the sample is taken and the state goes to DRAIN then DONE.
  - A byte already registered in flight is still sampled and counted.
  - The remaining stream is not consumed.
- Undefined: the full length is always scanned; there is no early exit.

Test Plan:
- key=0x40, length=4, bytes 0x10,0x40,0x80,0x40 back-to-back -> lt=1, eq=2, gt=1, match_index=1, match_found=1, done 2 cycles after last transfer, flag_error=0.
- length=0 with start -> done pulses the cycle after IDLE→DONE, all counters 0, data_ready never asserts.
- data_valid toggling 1,0,1,0 with key=0xFF, bytes 0x00,0xFF -> only 2 transfers counted, lt=1, eq=1, match_index=1.
- length=255, all bytes 0x00, key=0x01 -> lt_count=0xFF, eq=gt=0, match_found=0.
- Force cmp_gt=cmp_eq=1 on one sample -> flag_error=1 sticky, no counter change for that byte; cleared by next start.
- rst_n low mid-scan after 3 of 6 bytes -> all outputs 0 asynchronously. With COMPARE_SCAN_STOP_ON_MATCH_EN, key=0x22 and bytes 0x01,0x22,0x33 -> eq=1, lt=1, gt=0, third byte not accepted.
